nand_sweep_checker: RTL and testbench
=====================================

# nand_sweep_checker

Self-checking stimulus/response stage for the gate library. It drives the inputs of a NAND gate under test through every input combination and holds each one for a fixed number of cycles. It samples the gate output on the last hold cycle of each combination and compares it against the NAND truth value. It reports a mismatch count and a pass/fail verdict, so gate-level checks run in hardware or in a clocked bench without hand-written stimulus.

## Interface
Parameters:
- N_INPUTS, default 2: number of gate inputs swept; legal range 1..8.
- HOLD, default 3: cycles each input vector is held; legal minimum 1.

Ports:
- clk  input  1  single clock; all state updates on rising edge.
- reset  input  1  synchronous, active-high reset; one clock, no other clock domains.
- start  input  1  request a sweep; accepted only in IDLE.
- dut_in  output  N_INPUTS  vector driven to the gate under test (bit 0 = a, bit 1 = b).
- dut_out  input  1  gate-under-test output.
- busy  output  1  high while a sweep is running.
- done  output  1  one-cycle pulse when a sweep completes.
- pass  output  1  high when the last completed sweep had zero mismatches.
- err_count  output  N_INPUTS+1  mismatches in the current or last sweep.
- fail_vec  output  N_INPUTS  first failing vector (see Configuration).
- fail_valid  output  1  fail_vec holds a captured vector.

## Operation
- States: IDLE, DRIVE, DONE.
- IDLE -> DRIVE when start=1. On that edge:
  - dut_in=0, hold counter=0.
  - err_count=0, pass=0, fail_valid=0, fail_vec=0.
- DRIVE: busy=1. The hold counter increments every cycle.
- When hold counter == HOLD-1, dut_out is compared with expected = ~&dut_in.
  - A mismatch increments err_count.
  - X or Z on dut_out counts as a mismatch.
- On the same edge the hold counter clears, and dut_in increments unless it equals 2^N_INPUTS-1.
- DRIVE -> DONE on the comparison edge of the last vector. That edge also loads pass = (final err_count == 0), including the last comparison.
- DONE: busy=0, done=1 for exactly one cycle, then IDLE.
- err_count is never saturated: it holds at most 2^N_INPUTS.
- Held values:
  - dut_in holds the last vector after DONE until the next start.
  - pass, err_count, fail_vec and fail_valid hold until the next accepted start.
- start is ignored in DRIVE and DONE; there is no queuing.
- reset has priority over every event, including mid-sweep. It forces IDLE and all outputs to 0.

## Timing
- Reset values: dut_in=0, busy=0, done=0, pass=0, err_count=0, fail_vec=0, fail_valid=0.
- If start is sampled at edge 0, busy is high from edge 1 through edge 2^N_INPUTS·HOLD. This is 12 cycles for the defaults.
- done is high for the single cycle after the final comparison edge. For the defaults, done asserts at edge 13.
- Each vector is stable on dut_in for exactly HOLD cycles. It is sampled at the end of its last cycle, giving the gate HOLD-1 cycles of settle margin.
- Back-to-back sweeps: a start in the cycle after done (IDLE) is accepted, so the minimum gap between sweeps is one DONE plus one IDLE cycle.

## Configuration
- NAND_SWEEP_FAILCAP_EN defined: compiles in first-failure capture.
  - On the first mismatch of a sweep, fail_vec loads the failing dut_in and fail_valid sets.
  - Later mismatches do not overwrite fail_vec or fail_valid.
- Undefined: no capture registers are built. fail_vec and fail_valid are tied to 0.
- Ports are present in both builds. All other behaviour is identical.

## Test plan
- Correct NAND as DUT, defaults, start pulsed after reset:
  - Vectors 0,1,2,3 each last 3 cycles.
  - done at edge 13, pass=1, err_count=0, fail_valid=0.
- DUT stuck at 0: err_count=3, pass=0. With NAND_SWEEP_FAILCAP_EN: fail_vec=0, fail_valid=1.
- AND gate as DUT: err_count=4, pass=0. With capture enabled: fail_vec=0.
- start held high across the whole sweep: one sweep only, busy 12 cycles. A second sweep begins on the edge after DONE (start still high).
- reset asserted at edge 5 mid-sweep:
  - Next cycle all outputs are 0 and state is IDLE.
  - A new start gives a complete, correct 12-cycle sweep.
- N_INPUTS=3, HOLD=1, correct 3-input NAND: busy 8 cycles, dut_in steps 0..7 every cycle, pass=1, err_count=0.

Source files
------------

// File: rtl/nand_sweep_checker.sv
// -----------------------------------------------------------------------------
// nand_sweep_checker
//
// Exhaustive stimulus/response checker for a NAND gate under test. Every input
// combination is driven on dut_in, counting up from 0. Each combination is held
// for HOLD cycles. The gate output is sampled on the last hold cycle of each
// combination and compared against the NAND truth value. A sweep reports the
// number of mismatches and a pass/fail verdict.
//
// Parameters
//   N_INPUTS   number of gate inputs swept (1..8)
//   HOLD       cycles each vector is held (>= 1)
//
// Ports
//   clk         in   single clock, rising edge
//   reset       in   synchronous active-high reset
//   start       in   sweep request, honoured only while idle
//   dut_in      out  [N_INPUTS]   vector driven to the gate (bit 0 = a)
//   dut_out     in   gate output under test
//   busy        out  high while a sweep is running
//   done        out  one-cycle pulse after the final comparison
//   pass        out  last completed sweep had zero mismatches
//   err_count   out  [N_INPUTS+1] mismatches in current/last sweep
//   fail_vec    out  [N_INPUTS]   first failing vector (capture build only)
//   fail_valid  out  fail_vec holds a captured vector
//
// Build option
//   NAND_SWEEP_FAILCAP_EN  when defined, first-failure capture registers are
//                          built; otherwise fail_vec/fail_valid are tied to 0.
// -----------------------------------------------------------------------------
module nand_sweep_checker #(
    parameter int N_INPUTS = 2,
    parameter int HOLD     = 3
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                start,
    output logic [N_INPUTS-1:0] dut_in,
    input  logic                dut_out,
    output logic                busy,
    output logic                done,
    output logic                pass,
    output logic [N_INPUTS:0]   err_count,
    output logic [N_INPUTS-1:0] fail_vec,
    output logic                fail_valid
);

    // Controller states
    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_DRIVE = 2'd1;
    localparam logic [1:0] ST_DONE  = 2'd2;

    // Hold counter only needs to reach HOLD-1; keep at least one bit.
    localparam int HOLD_W = (HOLD > 1) ? $clog2(HOLD) : 1;

    localparam logic [HOLD_W-1:0]   HOLD_LAST = HOLD_W'(HOLD - 1);
    localparam logic [HOLD_W-1:0]   HOLD_ZERO = HOLD_W'(0);
    localparam logic [HOLD_W-1:0]   HOLD_ONE  = HOLD_W'(1);
    localparam logic [N_INPUTS-1:0] VEC_ZERO  = N_INPUTS'(0);
    localparam logic [N_INPUTS-1:0] VEC_ONE   = N_INPUTS'(1);
    localparam logic [N_INPUTS-1:0] VEC_LAST  = {N_INPUTS{1'b1}};
    localparam logic [N_INPUTS:0]   ERR_ZERO  = {(N_INPUTS+1){1'b0}};
    localparam logic [N_INPUTS:0]   ERR_ONE   = {{N_INPUTS{1'b0}}, 1'b1};

    // Truth value of an N-input NAND for the vector currently driven.
    function automatic logic nand_expect(input logic [N_INPUTS-1:0] vec);
        return ~(&vec);
    endfunction

    // -------------------------------------------------------------------------
    // State and output registers
    // -------------------------------------------------------------------------
    logic [1:0]          state_r;
    logic [HOLD_W-1:0]   hold_cnt_r;
    logic [N_INPUTS-1:0] dut_in_r;
    logic                busy_r;
    logic                done_r;
    logic                pass_r;
    logic [N_INPUTS:0]   err_count_r;

    // Next-state values
    logic [1:0]          state_s;
    logic [HOLD_W-1:0]   hold_cnt_s;
    logic [N_INPUTS-1:0] dut_in_s;
    logic                busy_s;
    logic                done_s;
    logic                pass_s;
    logic [N_INPUTS:0]   err_count_s;

    // Per-cycle decode
    logic                accept_s;
    logic                sample_s;
    logic                expected_s;
    logic                mismatch_s;
    logic [N_INPUTS:0]   err_inc_s;

    // Decode of start acceptance, sample point and comparison result
    always_comb begin
        accept_s   = 1'b0;
        sample_s   = 1'b0;
        mismatch_s = 1'b0;
        expected_s = nand_expect(dut_in_r);

        if (state_r == ST_IDLE) begin
            accept_s = start;
        end else begin
            accept_s = 1'b0;
        end

        if ((state_r == ST_DRIVE) && (hold_cnt_r == HOLD_LAST)) begin
            sample_s = 1'b1;
        end else begin
            sample_s = 1'b0;
        end

        // Case inequality so that X/Z on the gate output is a mismatch in
        // four-state simulation; hardware sees an ordinary inequality.
        if (sample_s && (dut_out !== expected_s)) begin
            mismatch_s = 1'b1;
        end else begin
            mismatch_s = 1'b0;
        end

        // Count never wraps: at most 2^N_INPUTS mismatches in an N+1 bit field.
        if (mismatch_s) begin
            err_inc_s = err_count_r + ERR_ONE;
        end else begin
            err_inc_s = err_count_r;
        end
    end

    // Sweep controller next-state logic
    always_comb begin
        state_s     = state_r;
        hold_cnt_s  = hold_cnt_r;
        dut_in_s    = dut_in_r;
        busy_s      = busy_r;
        done_s      = 1'b0;
        pass_s      = pass_r;
        err_count_s = err_count_r;

        case (state_r)
            ST_IDLE: begin
                if (accept_s) begin
                    state_s     = ST_DRIVE;
                    hold_cnt_s  = HOLD_ZERO;
                    dut_in_s    = VEC_ZERO;
                    busy_s      = 1'b1;
                    pass_s      = 1'b0;
                    err_count_s = ERR_ZERO;
                end else begin
                    busy_s = 1'b0;
                end
            end

            ST_DRIVE: begin
                busy_s = 1'b1;
                if (sample_s) begin
                    hold_cnt_s  = HOLD_ZERO;
                    err_count_s = err_inc_s;
                    if (dut_in_r == VEC_LAST) begin
                        // Last vector: verdict includes this comparison; the
                        // final vector stays on dut_in until the next start.
                        state_s = ST_DONE;
                        busy_s  = 1'b0;
                        done_s  = 1'b1;
                        pass_s  = (err_inc_s == ERR_ZERO);
                    end else begin
                        dut_in_s = dut_in_r + VEC_ONE;
                    end
                end else begin
                    hold_cnt_s = hold_cnt_r + HOLD_ONE;
                end
            end

            ST_DONE: begin
                // start is ignored here; IDLE is entered unconditionally.
                state_s = ST_IDLE;
                busy_s  = 1'b0;
                done_s  = 1'b0;
            end

            default: begin
                state_s    = ST_IDLE;
                hold_cnt_s = HOLD_ZERO;
                busy_s     = 1'b0;
                done_s     = 1'b0;
            end
        endcase
    end

    // Controller and result registers with synchronous reset priority
    always_ff @(posedge clk) begin
        if (reset) begin
            state_r     <= ST_IDLE;
            hold_cnt_r  <= HOLD_ZERO;
            dut_in_r    <= VEC_ZERO;
            busy_r      <= 1'b0;
            done_r      <= 1'b0;
            pass_r      <= 1'b0;
            err_count_r <= ERR_ZERO;
        end else begin
            state_r     <= state_s;
            hold_cnt_r  <= hold_cnt_s;
            dut_in_r    <= dut_in_s;
            busy_r      <= busy_s;
            done_r      <= done_s;
            pass_r      <= pass_s;
            err_count_r <= err_count_s;
        end
    end

    assign dut_in    = dut_in_r;
    assign busy      = busy_r;
    assign done      = done_r;
    assign pass      = pass_r;
    assign err_count = err_count_r;

`ifdef NAND_SWEEP_FAILCAP_EN
    // -------------------------------------------------------------------------
    // First-failure capture
    // -------------------------------------------------------------------------
    logic [N_INPUTS-1:0] fail_vec_r;
    logic                fail_valid_r;
    logic [N_INPUTS-1:0] fail_vec_s;
    logic                fail_valid_s;

    // Clear on an accepted start, then latch only the first mismatch
    always_comb begin
        fail_vec_s   = fail_vec_r;
        fail_valid_s = fail_valid_r;
        if (accept_s) begin
            fail_vec_s   = VEC_ZERO;
            fail_valid_s = 1'b0;
        end else if (mismatch_s && !fail_valid_r) begin
            fail_vec_s   = dut_in_r;
            fail_valid_s = 1'b1;
        end else begin
            fail_vec_s   = fail_vec_r;
            fail_valid_s = fail_valid_r;
        end
    end

    // Capture registers
    always_ff @(posedge clk) begin
        if (reset) begin
            fail_vec_r   <= VEC_ZERO;
            fail_valid_r <= 1'b0;
        end else begin
            fail_vec_r   <= fail_vec_s;
            fail_valid_r <= fail_valid_s;
        end
    end

    assign fail_vec   = fail_vec_r;
    assign fail_valid = fail_valid_r;
`else
    assign fail_vec   = VEC_ZERO;
    assign fail_valid = 1'b0;
`endif

endmodule

// File: tb/tb_nand_sweep_checker.sv
// Directed bench for nand_sweep_checker: default 2-input/HOLD=3 instance with a
// selectable gate model, plus a 3-input/HOLD=1 instance with a correct NAND3.
module tb_nand_sweep_checker;

`ifdef NAND_SWEEP_FAILCAP_EN
    localparam bit CAP = 1'b1;
`else
    localparam bit CAP = 1'b0;
`endif

    typedef struct {
        int err;
        int pass;
        int fvec;
        int fvalid;
    } sum_t;

    logic       clk = 1'b0;
    logic       reset;
    logic       start;
    logic [1:0] dut_in;
    logic       dut_out;
    logic       busy, done, pass, fail_valid;
    logic [2:0] err_count;
    logic [1:0] fail_vec;

    logic       start3;
    logic [2:0] dut_in3;
    logic       dut_out3;
    logic       busy3, done3, pass3, fail_valid3;
    logic [3:0] err_count3;
    logic [2:0] fail_vec3;

    int gate_mode = 0;   // 0 NAND, 1 stuck-at-0, 2 AND
    int n_cmp  = 0;
    int n_fail = 0;

    int   vec_q[$];
    sum_t sum_q[$];

    always #5 clk = ~clk;

    nand_sweep_checker #(.N_INPUTS(2), .HOLD(3)) dut (
        .clk(clk), .reset(reset), .start(start), .dut_in(dut_in),
        .dut_out(dut_out), .busy(busy), .done(done), .pass(pass),
        .err_count(err_count), .fail_vec(fail_vec), .fail_valid(fail_valid)
    );

    nand_sweep_checker #(.N_INPUTS(3), .HOLD(1)) dut3 (
        .clk(clk), .reset(reset), .start(start3), .dut_in(dut_in3),
        .dut_out(dut_out3), .busy(busy3), .done(done3), .pass(pass3),
        .err_count(err_count3), .fail_vec(fail_vec3), .fail_valid(fail_valid3)
    );

    // Gate models driven by the checkers
    always_comb begin
        case (gate_mode)
            1:       dut_out = 1'b0;
            2:       dut_out = &dut_in;
            default: dut_out = ~&dut_in;
        endcase
        dut_out3 = ~&dut_in3;
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Expected dut_in per cycle and end-of-sweep results
    task automatic push_sweep(input int err, input int ps, input int fv, input int fval);
        sum_t s;
        for (int v = 0; v < 4; v++)
            for (int h = 0; h < 3; h++)
                vec_q.push_back(v);
        s.err = err; s.pass = ps;
        s.fvec = CAP ? fv : 0;
        s.fvalid = CAP ? fval : 0;
        sum_q.push_back(s);
    endtask

    // Entered just after the edge that accepted start
    task automatic check_sweep();
        sum_t s;
        for (int c = 0; c < 12; c++) begin
            check("busy_run", busy, 1);
            check("dut_in", dut_in, vec_q.pop_front());
            check("done_low_run", done, 0);
            tick();
        end
        s = sum_q.pop_front();
        check("done_pulse", done, 1);
        check("busy_end", busy, 0);
        check("dut_in_last", dut_in, 3);
        check("err_count", err_count, s.err);
        check("pass", pass, s.pass);
        check("fail_vec", fail_vec, s.fvec);
        check("fail_valid", fail_valid, s.fvalid);
        tick();
        check("done_one_cycle", done, 0);
        check("busy_after", busy, 0);
        check("pass_hold", pass, s.pass);
        check("err_hold", err_count, s.err);
        check("dut_in_hold", dut_in, 3);
    endtask

    task automatic run_sweep(input int mode, input int err, input int ps,
                             input int fv, input int fval, input bit keep_start);
        gate_mode = mode;
        start = 1'b1;
        push_sweep(err, ps, fv, fval);
        tick();
        if (!keep_start) start = 1'b0;
        check_sweep();
    endtask

    initial begin
        reset = 1'b1; start = 1'b0; start3 = 1'b0;
        repeat (3) tick();
        reset = 1'b0;
        tick();

        check("rst_dut_in", dut_in, 0);
        check("rst_busy", busy, 0);
        check("rst_done", done, 0);
        check("rst_pass", pass, 0);
        check("rst_err", err_count, 0);
        check("rst_fail_vec", fail_vec, 0);
        check("rst_fail_valid", fail_valid, 0);

        // Correct NAND, stuck-at-0, AND
        run_sweep(0, 0, 1, 0, 0, 1'b0);
        run_sweep(1, 3, 0, 0, 1, 1'b0);
        run_sweep(2, 4, 0, 0, 1, 1'b0);

        // start held through the sweep: second sweep begins after DONE+IDLE
        run_sweep(0, 0, 1, 0, 0, 1'b1);
        push_sweep(0, 1, 0, 0);
        tick();
        start = 1'b0;
        check_sweep();

        // Stuck-at-0 sweep, then reset at edge 5 of the next sweep
        run_sweep(1, 3, 0, 0, 1, 1'b0);
        gate_mode = 0;
        start = 1'b1;
        tick();                 // edge 0
        start = 1'b0;
        repeat (4) tick();      // after edge 4
        check("mid_busy", busy, 1);
        check("mid_dut_in", dut_in, 1);
        reset = 1'b1;
        tick();                 // edge 5
        reset = 1'b0;
        check("rst2_dut_in", dut_in, 0);
        check("rst2_busy", busy, 0);
        check("rst2_done", done, 0);
        check("rst2_pass", pass, 0);
        check("rst2_err", err_count, 0);
        check("rst2_fail_vec", fail_vec, 0);
        check("rst2_fail_valid", fail_valid, 0);
        tick();
        check("rst2_idle_busy", busy, 0);
        run_sweep(0, 0, 1, 0, 0, 1'b0);

        // 3-input, HOLD=1 instance
        for (int v = 0; v < 8; v++) vec_q.push_back(v);
        start3 = 1'b1;
        tick();
        start3 = 1'b0;
        for (int c = 0; c < 8; c++) begin
            check("n3_busy", busy3, 1);
            check("n3_dut_in", dut_in3, vec_q.pop_front());
            tick();
        end
        check("n3_done", done3, 1);
        check("n3_busy_end", busy3, 0);
        check("n3_pass", pass3, 1);
        check("n3_err", err_count3, 0);
        check("n3_fail_valid", fail_valid3, 0);
        tick();
        check("n3_done_one_cycle", done3, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
